conv_2d_ctrl: RTL
=================

Name: conv_2d_ctrl

Overview:
- Sequencer for the 3x3 conv_2d datapath.
- Accepts a 3-beat kernel load, then streams 3-row pixel columns, one column per accepted beat.
- Drives the datapath's load and enable strobes and tags which conv_2d outputs are full-window valid, with output coordinates.
- Sits between the line-buffer/column source and conv_2d; the control path carries no pixel or coefficient data.

Parameters:
- IMG_W, 640, input columns per row pass (>=3).
- IMG_H, 480, input image rows (>=3); output rows = IMG_H-2.
- CONV_LAT, 2, enabled cycles from an o_en_conv beat to its o_pixel at the conv_2d output (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  frame start pulse; honoured only in IDLE.
- i_skip_knl  in  1  sampled with i_start; 1 = reuse the loaded kernel and skip LOAD_KNL.
- i_knl_valid  in  1  kernel column beat present on the datapath's i_data1..3.
- o_knl_ready  out  1  kernel beat accepted when ready and valid.
- i_pix_valid  in  1  pixel column present on i_data1..3.
- o_pix_ready  out  1  pixel beat accepted when ready and valid.
- o_load_knl  out  1  to conv_2d i_load_knl.
- o_en_conv  out  1  to conv_2d i_en_conv.
- o_out_valid  out  1  current conv_2d o_pixel is a full-window result.
- o_out_col  out  $clog2(IMG_W)  output column of the valid result, 0..IMG_W-3.
- o_out_row  out  $clog2(IMG_H)  output row of the valid result, 0..IMG_H-3.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse when the frame is fully flushed.

Behaviour:
- Reset state: all outputs 0; state IDLE; counters and valid pipe cleared.
- Reset mid-frame aborts immediately with the same result; no o_done is issued.

State machine: IDLE, LOAD_KNL, STREAM, DRAIN, DONE.
- IDLE:
  - i_start with i_skip_knl=0 goes to LOAD_KNL.
  - i_start with i_skip_knl=1 goes to STREAM.
  - Before any kernel load, i_skip_knl is honoured anyway; kernel contents are then undefined.
- LOAD_KNL:
  - o_knl_ready=1.
  - o_load_knl = i_knl_valid (combinational), so each accepted beat shifts one kernel column into conv_2d.
  - After the 3rd accepted beat, go to STREAM.
- STREAM:
  - o_pix_ready=1; o_en_conv = i_pix_valid (combinational).
  - Bubbles (i_pix_valid=0) hold everything; no counter or pipe advance.
  - Each accepted beat increments col (0..IMG_W-1).
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - Accepting the last beat of row IMG_H-3 goes to DRAIN.
- DRAIN:
  - o_en_conv=1, o_pix_ready=0 for exactly CONV_LAT cycles to flush the pipe.
  - Flushed window contents are never marked valid.
  - Then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored.

Valid tagging:
- A beat at col>=2 is a full window, tagged with coordinates (col-2, row).
- The tag enters a CONV_LAT-deep shift register that advances only on o_en_conv cycles, matching conv_2d gating every stage on i_en_conv.
- o_out_valid, o_out_col and o_out_row come from the register tail and are qualified by o_en_conv (all 0 when o_en_conv=0).
- Result: the result of a beat is flagged on the CONV_LAT-th subsequent enabled cycle.
- Columns 0 and 1 of every row pass fill the window and are never valid.

Totals per frame:
- Accepted pixel beats = IMG_W*(IMG_H-2).
- Valid outputs = (IMG_W-2)*(IMG_H-2).
- Kernel beats = 3, or 0 when skipped.

Optional Feature:
- Macro: CONV_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt, 32 bits.
  - Counts STREAM cycles with i_pix_valid=0; saturates at 2^32-1.
  - Cleared by i_rst and on every accepted i_start.
  - Holds its value after DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Basic frame. Config: IMG_W=5, IMG_H=4, CONV_LAT=2. Stimulus: i_start, 3 kernel beats, then 10 back-to-back pixel beats. Required response:
   - o_load_knl high exactly 3 cycles.
   - 6 o_out_valid pulses with (col,row) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
   - 2 DRAIN cycles with o_en_conv=1, then o_done single pulse, o_busy low next cycle.
2. Bubbles. Same frame with i_pix_valid toggling 1,0,1,0:
   - o_en_conv only on accepted beats.
   - Same 6 coordinates in the same order.
   - With CONV_CTRL_STALL_CNT_EN: o_stall_cnt=9.
3. Skip kernel. i_start with i_skip_knl=1 -> o_knl_ready never asserts and STREAM is entered the next cycle; i_knl_valid held 1 causes no o_load_knl.
4. Reset mid-frame. Assert i_rst after the 4th pixel beat ->
   - Next cycle: all outputs 0, state IDLE, no o_done.
   - A fresh i_start then produces the full 6-valid sequence from (0,0).
5. Ignored start. Pulse i_start during STREAM and during DRAIN -> no state or counter change; exactly one o_done per frame.
6. Latency sweep. CONV_LAT=1 and CONV_LAT=4 -> the first o_out_valid is on the 1st and 4th enabled cycle after the col=2 beat respectively; DRAIN length equals CONV_LAT.

Source files
------------

// File: rtl/conv_2d_ctrl.sv
// Sequencer for the 3x3 conv_2d datapath: kernel load, pixel streaming, drain, valid tagging.
// Optional macro CONV_CTRL_STALL_CNT_EN adds o_stall_cnt (saturating STREAM bubble counter).
module conv_2d_ctrl #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned CONV_LAT = 2
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_skip_knl,
  input  logic                       i_knl_valid,
  output logic                       o_knl_ready,
  input  logic                       i_pix_valid,
  output logic                       o_pix_ready,
  output logic                       o_load_knl,
  output logic                       o_en_conv,
  output logic                       o_out_valid,
  output logic [$clog2(IMG_W)-1:0]   o_out_col,
  output logic [$clog2(IMG_H)-1:0]   o_out_row,
`ifdef CONV_CTRL_STALL_CNT_EN
  output logic [31:0]                o_stall_cnt,
`endif
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned DW = $clog2(CONV_LAT + 1);

  typedef enum logic [2:0] {StIdle, StLoadKnl, StStream, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    knl_cnt_q, knl_cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          start_acc;
  logic          en;

  // Tag pipe mirrors the conv_2d stages; it only moves on enabled cycles.
  logic          pipe_vld_q [CONV_LAT];
  logic          pipe_vld_d [CONV_LAT];
  logic [CW-1:0] pipe_col_q [CONV_LAT];
  logic [CW-1:0] pipe_col_d [CONV_LAT];
  logic [RW-1:0] pipe_row_q [CONV_LAT];
  logic [RW-1:0] pipe_row_d [CONV_LAT];

  always_comb begin
    state_d     = state_q;
    knl_cnt_d   = knl_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_cnt_d = drain_cnt_q;
    start_acc   = 1'b0;
    en          = 1'b0;
    o_knl_ready = 1'b0;
    o_load_knl  = 1'b0;
    o_pix_ready = 1'b0;
    o_done      = 1'b0;
    o_busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          start_acc   = 1'b1;
          knl_cnt_d   = '0;
          col_d       = '0;
          row_d       = '0;
          drain_cnt_d = '0;
          state_d     = i_skip_knl ? StStream : StLoadKnl;
        end
      end
      StLoadKnl: begin
        o_knl_ready = 1'b1;
        o_load_knl  = i_knl_valid;
        if (i_knl_valid) begin
          if (knl_cnt_q == 2'd2) begin
            knl_cnt_d = '0;
            state_d   = StStream;
          end else begin
            knl_cnt_d = knl_cnt_q + 2'd1;
          end
        end
      end
      StStream: begin
        o_pix_ready = 1'b1;
        en          = i_pix_valid;
        if (i_pix_valid) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H - 3)) begin
              row_d   = '0;
              state_d = StDrain;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      StDrain: begin
        en = 1'b1;
        if (drain_cnt_q == DW'(CONV_LAT - 1)) begin
          drain_cnt_d = '0;
          state_d     = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CONV_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i];
      pipe_col_d[i] = pipe_col_q[i];
      pipe_row_d[i] = pipe_row_q[i];
    end
    if (en) begin
      // Drain beats push invalid tags so flushed windows are never flagged.
      pipe_vld_d[0] = (state_q == StStream) && (col_q >= CW'(2));
      pipe_col_d[0] = col_q - CW'(2);
      pipe_row_d[0] = row_q;
      for (int i = 1; i < CONV_LAT; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
        pipe_col_d[i] = pipe_col_q[i-1];
        pipe_row_d[i] = pipe_row_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      knl_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_cnt_q <= '0;
      for (int i = 0; i < CONV_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_col_q[i] <= '0;
        pipe_row_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      knl_cnt_q   <= knl_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_cnt_q <= drain_cnt_d;
      for (int i = 0; i < CONV_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_col_q[i] <= pipe_col_d[i];
        pipe_row_q[i] <= pipe_row_d[i];
      end
    end
  end

  assign o_en_conv   = en;
  assign o_out_valid = en & pipe_vld_q[CONV_LAT-1];
  assign o_out_col   = o_out_valid ? pipe_col_q[CONV_LAT-1] : '0;
  assign o_out_row   = o_out_valid ? pipe_row_q[CONV_LAT-1] : '0;

`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if ((state_q == StStream) && !i_pix_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
